proc_controller: RTL and testbench
==================================

# proc_controller

Control unit of the ProjectB 16-bit processor, acting as the initiator side of the register-file port set.
- Fetches instructions from instruction memory and decodes them with a Moore state machine.
- Drives the register file's read addresses, write address and write enable.
- Also drives data-memory address/write, the register-write data mux select and the ALU function select.
- Sits between instruction memory and the datapath (register file, ALU, data memory).

## Interface
Parameters:
- PC_W, 7, program counter / instruction memory address width
- DA_W, 8, data memory address width
- RA_W, 4, register file address width (16 registers)

Ports:
- clk  in  1  system clock; one clock
- reset  in  1  synchronous, active-high reset
- instr  in  16  instruction word at pc_addr, valid during Fetch
- pc_addr  out  PC_W  instruction memory address
- ir_out  out  16  instruction register contents (debug)
- state_out  out  4  current state encoding (debug)
- d_addr  out  DA_W  data memory address
- d_wr  out  1  data memory write enable
- rf_s  out  1  register-write data select: 0 = ALU result, 1 = data memory read data
- rf_w_addr  out  RA_W  register file write address
- rf_w_en  out  1  register file write enable
- rf_ra_addr  out  RA_W  register file A-side read address
- rf_rb_addr  out  RA_W  register file B-side read address
- alu_s0  out  3  ALU function: 0 pass-A, 1 add, 2 subtract
- halted  out  1  high while in Halt

## Operation
- Instruction format, opcode in [15:12]:
  - NOOP 0000
  - STORE 0001: Ra=[11:8], daddr=[7:0]
  - LOAD 0010: daddr=[11:4], Rd=[3:0]
  - ADD 0011 / SUB 0100: Ra=[11:8], Rb=[7:4], Rc=[3:0]
  - HALT 0101
  - Opcodes 0110–1111 execute as NOOP.
- States: Init, Fetch, Decode, Noop, LoadA, LoadB, Store, Add, Sub, Halt.
- Transitions:
  - Init→Fetch
  - Fetch→Decode
  - Decode→{Noop, LoadA, Store, Add, Sub, Halt} by opcode
  - LoadA→LoadB
  - Noop, LoadB, Store, Add and Sub each →Fetch
  - Halt→Halt
- Fetch: IR ← instr and PC ← PC+1 on the same edge. PC wraps modulo 2^PC_W (127→0).
- Outputs are Moore, decoded from state and IR only. Every output is 0 unless listed below.
  - LoadA: d_addr=IR[11:4], rf_s=1, rf_w_addr=IR[3:0].
  - LoadB: same as LoadA, plus rf_w_en=1.
  - Store: d_addr=IR[7:0], rf_ra_addr=IR[11:8], d_wr=1.
  - Add: rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], rf_w_addr=IR[3:0], rf_w_en=1, alu_s0=1.
  - Sub: same fields as Add, with alu_s0=2.
  - Halt: halted=1.
- pc_addr and ir_out always reflect the registers.

## Timing
- Reset (sampled at posedge) → state=Init, PC=0, IR=0. All outputs are 0 the cycle after the edge.
- Reset asserted in any state, including mid-LOAD or Halt, aborts at the next edge. No further d_wr or rf_w_en pulses occur once reset is sampled.
- Instruction latency, from Fetch entry to return to Fetch:
  - NOOP, STORE, ADD, SUB: 3 cycles
  - LOAD: 4 cycles
- Register file and data memory sample on the posedge that ends the asserting state. Each write instruction therefore produces exactly one write.
- LOAD gives the data memory one full cycle (LoadA) of address setup before the write cycle (LoadB).
- Halt is left only by reset.

## Structure
- Shared package proc_pkg holds:
  - opcode enum: OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT
  - state enum (4-bit)
  - ALU select constants ALU_PASS, ALU_ADD, ALU_SUB
  - field-slice constants for the instruction format
- One sub-module, program_counter: PC_W-bit register with synchronous clear (reset) and increment enable (asserted in Fetch); outputs pc_addr.
- IR register, state register and output decode live in proc_controller.

## Test plan
- Reset then instr=16'h3123 (ADD) → Fetch, Decode, Add. In Add: rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=3, rf_w_en=1, alu_s0=1; pc_addr=1 afterwards.
- instr=16'h21B5 (LOAD) → LoadA: d_addr=8'h1B, rf_s=1, rf_w_en=0. LoadB: rf_w_en=1, rf_w_addr=5. Back to Fetch 4 cycles after Fetch.
- instr=16'h17C4 (STORE) → Store: d_addr=8'hC4, rf_ra_addr=7, d_wr=1 for exactly one cycle. SUB 16'h4A9F → alu_s0=2, rf_w_addr=15.
- instr=16'h5000 (HALT) → halted=1 and pc_addr frozen for 20 cycles. instr=16'hF000 → behaves as NOOP, 3 cycles.
- PC preset near wrap with NOOP stream → pc_addr goes 127→0.
- Reset asserted during LoadA → next cycle state=Init, pc_addr=0, rf_w_en never asserted.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the ProjectB control unit: opcodes, FSM states,
// ALU select codes and instruction field positions.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_e;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // LSB positions of the instruction fields; widths come from the parameters.
  localparam int OPC_LSB     = 12;
  localparam int RA_LSB      = 8;
  localparam int RB_LSB      = 4;
  localparam int RC_LSB      = 0;
  localparam int LD_ADDR_LSB = 4;
  localparam int LD_RD_LSB   = 0;
  localparam int ST_ADDR_LSB = 0;

endpackage

// File: rtl/proc_controller_program_counter.sv
// Instruction address register: synchronous clear, +1 per fetch, natural wrap.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [PC_W-1:0] pc_addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_addr <= '0;
    end else if (inc) begin
      pc_addr <= pc_addr + 1'b1;
    end
  end

endmodule

// File: rtl/proc_controller.sv
// ProjectB control unit: fetch/decode Moore FSM driving the register file,
// data memory and ALU select from the state and the instruction register.
module proc_controller
  import proc_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] pc_addr,
  output logic [15:0]     ir_out,
  output logic [3:0]      state_out,
  output logic [DA_W-1:0] d_addr,
  output logic            d_wr,
  output logic            rf_s,
  output logic [RA_W-1:0] rf_w_addr,
  output logic            rf_w_en,
  output logic [RA_W-1:0] rf_ra_addr,
  output logic [RA_W-1:0] rf_rb_addr,
  output logic [2:0]      alu_s0,
  output logic            halted
);

  state_e      state;
  state_e      next_state;
  logic [15:0] ir;
  logic [3:0]  opcode;

  assign opcode    = ir[OPC_LSB +: 4];
  assign ir_out    = ir;
  assign state_out = state;

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .inc     (state == S_FETCH),
    .pc_addr (pc_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) begin
        ir <= instr;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        // Unassigned opcodes fall through to NOOP.
        case (opcode)
          OP_STORE: next_state = S_STORE;
          OP_LOAD:  next_state = S_LOADA;
          OP_ADD:   next_state = S_ADD;
          OP_SUB:   next_state = S_SUB;
          OP_HALT:  next_state = S_HALT;
          default:  next_state = S_NOOP;
        endcase
      end
      S_LOADA:  next_state = S_LOADB;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_s0     = ALU_PASS;
    halted     = 1'b0;
    case (state)
      S_LOADA, S_LOADB: begin
        // LoadA holds the address a full cycle before LoadB commits the write.
        d_addr    = ir[LD_ADDR_LSB +: DA_W];
        rf_s      = 1'b1;
        rf_w_addr = ir[LD_RD_LSB +: RA_W];
        rf_w_en   = (state == S_LOADB);
      end
      S_STORE: begin
        d_addr     = ir[ST_ADDR_LSB +: DA_W];
        rf_ra_addr = ir[RA_LSB +: RA_W];
        d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = ir[RA_LSB +: RA_W];
        rf_rb_addr = ir[RB_LSB +: RA_W];
        rf_w_addr  = ir[RC_LSB +: RA_W];
        rf_w_en    = 1'b1;
        alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_controller.sv
// Bench for proc_controller: program image in a local instruction memory,
// per-instruction expectations queued up front and checked as states appear.
module tb_proc_controller;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr;
  logic [6:0]  pc_addr;
  logic [15:0] ir_out;
  logic [3:0]  state_out;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_en;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [2:0]  alu_s0;
  logic        halted;

  logic [15:0] imem [0:127];
  logic [37:0] exp_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic        fetch_seen = 1'b0;
  int          since = 0;
  logic [37:0] obs;

  always #5 clk = ~clk;

  assign instr = imem[pc_addr];

  proc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .pc_addr    (pc_addr),
    .ir_out     (ir_out),
    .state_out  (state_out),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_s0     (alu_s0),
    .halted     (halted)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic [3:0] st, input logic [6:0] pc,
                                     input logic [7:0] da, input logic dw, input logic rs,
                                     input logic [3:0] wa, input logic we, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [2:0] alu, input logic h);
    return {st, pc, da, dw, rs, wa, we, ra, rb, alu, h};
  endfunction

  // Queue the execute-state outputs and fetch-to-fetch latency of one instruction.
  task automatic push_instr(input logic [15:0] ins, input logic [6:0] pc);
    case (ins[15:12])
      4'd1: begin
        exp_q.push_back(mk(S_STORE, pc, ins[7:0], 1'b1, 1'b0, 4'd0, 1'b0, ins[11:8], 4'd0, 3'd0, 1'b0));
        lat_q.push_back(3);
      end
      4'd2: begin
        exp_q.push_back(mk(S_LOADA, pc, ins[11:4], 1'b0, 1'b1, ins[3:0], 1'b0, 4'd0, 4'd0, 3'd0, 1'b0));
        exp_q.push_back(mk(S_LOADB, pc, ins[11:4], 1'b0, 1'b1, ins[3:0], 1'b1, 4'd0, 4'd0, 3'd0, 1'b0));
        lat_q.push_back(4);
      end
      4'd3: begin
        exp_q.push_back(mk(S_ADD, pc, 8'd0, 1'b0, 1'b0, ins[3:0], 1'b1, ins[11:8], ins[7:4], 3'd1, 1'b0));
        lat_q.push_back(3);
      end
      4'd4: begin
        exp_q.push_back(mk(S_SUB, pc, 8'd0, 1'b0, 1'b0, ins[3:0], 1'b1, ins[11:8], ins[7:4], 3'd2, 1'b0));
        lat_q.push_back(3);
      end
      4'd5: begin
        for (int i = 0; i < 20; i++)
          exp_q.push_back(mk(S_HALT, pc, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1));
      end
      default: begin
        exp_q.push_back(mk(S_NOOP, pc, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0));
        lat_q.push_back(3);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs = {state_out, pc_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
             rf_ra_addr, rf_rb_addr, alu_s0, halted};
      if (state_out == S_FETCH) begin
        if (fetch_seen) begin
          if (lat_q.size() > 0) check_eq("latency", 64'(since + 1), 64'(lat_q.pop_front()));
          else check_eq("unexpected_fetch", 64'(since + 1), 64'd0);
        end
        fetch_seen = 1'b1;
        since = 0;
      end else begin
        since++;
      end
      if (state_out != S_INIT && state_out != S_FETCH && state_out != S_DECODE) begin
        if (exp_q.size() > 0) check_eq("exec", 64'(obs), 64'(exp_q.pop_front()));
        else check_eq("unexpected_exec", 64'(obs), 64'd0);
      end else begin
        check_eq("idle_ctl", 64'(obs[26:0]), 64'd0);
      end
    end
  end

  // Reset, queue expectations for the first n instructions, run until drained.
  task automatic run_prog(input int n);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_outs", 64'({state_out, pc_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
                                rf_ra_addr, rf_rb_addr, alu_s0, halted}), 64'd0);
    check_eq("reset_ir", 64'(ir_out), 64'd0);
    exp_q.delete();
    lat_q.delete();
    fetch_seen = 1'b0;
    for (int k = 0; k < n; k++) push_instr(imem[k % 128], 7'((k + 1) % 128));
    reset = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 4000 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      #1;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    logic [15:0] dir_prog [0:5];
    logic [15:0] ins;
    dir_prog[0] = 16'h3123;
    dir_prog[1] = 16'h21B5;
    dir_prog[2] = 16'h17C4;
    dir_prog[3] = 16'h4A9F;
    dir_prog[4] = 16'hF000;
    dir_prog[5] = 16'h5000;

    // Directed program from the plan, ending in HALT.
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 6; i++) imem[i] = dir_prog[i];
    run_prog(6);
    check_eq("halt_pc_frozen", 64'(pc_addr), 64'd6);
    check_eq("halted", 64'(halted), 64'd1);

    // NOOP stream across the PC wrap.
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    run_prog(130);
    check_eq("pc_wrapped", 64'(pc_addr), 64'd2);

    // Random mix of operations, closed with HALT.
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom_range(0, 65535));
      if (ins[15:12] == 4'd5) ins[15:12] = 4'd2;
      imem[i] = ins;
    end
    imem[40] = 16'h5000;
    run_prog(41);
    check_eq("rand_halted", 64'(halted), 64'd1);

    // Reset arriving during LoadA.
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    imem[0] = 16'h21B5;
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10 && state_out != S_LOADA; c++) begin
      @(negedge clk);
      #1;
    end
    check_eq("reach_loada", 64'(state_out), 64'(S_LOADA));
    check_eq("loada_d_addr", 64'(d_addr), 64'h1B);
    check_eq("loada_no_wen", 64'(rf_w_en), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("abort_state", 64'(state_out), 64'(S_INIT));
    check_eq("abort_pc", 64'(pc_addr), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check_eq("abort_no_wen", 64'({rf_w_en, d_wr}), 64'd0);
      @(negedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
